seq_shift_unit: RTL and testbench
=================================

// Module: seq_shift_unit
// PURPOSE
//  Parametrised multi-cycle shift unit; successor to the 16-bit combinational
//  left arithmetic shifter. Supports LSL/LSR/ASL/ASR (+ optional rotates).
//  Variable shift amount, executed iteratively at one bit per clock.
//  valid/ready handshake on both sides; sits between the ALU operand latch
//  and the result writeback.
// PARAMETERS
//  WIDTH   16              data width; power of two, >= 4
//  SHW     $clog2(WIDTH)   localparam: shift-amount width (max WIDTH-1)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operand/op/shamt valid
//  in_ready   out  1      unit idle, can accept
//  op         in   3      000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR
//  a          in   WIDTH  operand
//  shamt      in   SHW    shift amount N
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  y          out  WIDTH  result
//  c          out  1      last bit shifted/rotated out (0 if N==0)
//  of         out  1      signed overflow (ASL only, sticky over all steps)
// BEHAVIOUR
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE. in_ready = (state==IDLE) && !rst.
//  - Accept when in_valid && in_ready at edge k: latch a, op, cnt=N; clear c, of;
//    go to SHIFT.
//  - SHIFT, cnt!=0: one 1-bit step per edge, cnt-=1. SHIFT, cnt==0: go to DONE,
//    no step. out_valid rises after edge k+N+1 (latency N+1, min 1).
//  - Per step: LSL {y[W-2:0],0}; LSR {0,y[W-1:1]}; ASL as LSL; ASR {y[W-1],y[W-1:1]};
//    ROL {y[W-2:0],y[W-1]}; ROR {y[0],y[W-1:1]}. c <= bit leaving the word.
//  - of: ASL only; set if any step has y[W-1]!=y[W-2] pre-step; 0 for other ops.
//  - DONE: out_valid=1; y/c/of stable until out_valid && out_ready, then IDLE.
//    in_ready stays 0 in DONE (no overlap); throughput 1 op per N+3 cycles min.
//  - in_valid while busy is ignored; the upstream holds it.
//  - Inputs a/op/shamt are sampled only at accept; later changes have no effect.
//  - Reset, including mid-op: state=IDLE, y=0, c=0, of=0, out_valid=0, cnt=0.
//    The in-flight op is discarded.
// CONFIGURATION
//  SEQ_SHIFT_ROT_EN defined: op 100/101 perform ROL/ROR per above, c = bit
//    rotated around, of=0.
//  Not defined: op[2]==1 is a pass-through. y=a, c=0, of=0, still N+1 latency.
//    No rotate datapath is built.
// TESTING
//  1. ASL a=16'h4000 N=1 -> y=16'h8000 of=1 c=0; out_valid 2 cycles after accept.
//  2. LSR a=16'h8001 N=4 -> y=16'h0800 c=0 of=0; ASR a=16'h8000 N=15 -> y=16'hFFFF c=0.
//  3. LSL a=16'h1234 N=0 -> y=16'h1234 c=0 of=0, latency 1; in_ready=0 until consumed.
//  4. Backpressure: out_ready=0 for 5 cycles -> y/c/of/out_valid held;
//     a second in_valid is not accepted.
//  5. rst pulse mid-SHIFT (LSL N=10, after 3 steps) -> all outputs 0, in_ready=1;
//     next op runs correctly.
//  6. SEQ_SHIFT_ROT_EN: ROL a=16'h8001 N=1 -> y=16'h0003 c=1. Without the macro,
//     same stimulus -> y=16'h8001 c=0.

Source files
------------

// File: rtl/seq_shift_if.sv
// Operand/result handshake bundle for seq_shift_unit.
// master: the producer/consumer side (drives operands and out_ready).
// slave : the shift unit itself.
interface seq_shift_if #(
    parameter int WIDTH = 16
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             of;

    modport master (
        output in_valid, op, a, shamt, out_ready,
        input  in_ready, out_valid, y, c, of
    );

    modport slave (
        input  in_valid, op, a, shamt, out_ready,
        output in_ready, out_valid, y, c, of
    );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative shifter, one bit position per clock.
// Ops: 000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR.
// Optional feature macro: SEQ_SHIFT_ROT_EN
//   defined     -> op 100/101 rotate left/right.
//   not defined -> op[2]==1 passes the operand through unchanged (same latency),
//                  and no rotate datapath exists.
// Latency from accept to out_valid is N+1 cycles; result is held until consumed.
module seq_shift_unit #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    seq_shift_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] y_reg;
    logic             c_reg;
    logic             of_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [2:0]       op_reg;

    logic             in_ready_int;
    logic             out_valid_int;
    logic             accept;
    logic             step_en;
    logic [WIDTH-1:0] step_y;
    logic             step_c;
    logic             step_of;

    assign accept  = bus.in_valid && in_ready_int;
    assign step_en = (state_reg == SHIFT) && (cnt_reg != '0);

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: SHIFT leaves only once the step counter has run out,
    // DONE leaves only when the consumer takes the result.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)                       state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0)                state_next = DONE;
            DONE:    if (out_valid_int && bus.out_ready) state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is forced low during reset.
    always_comb begin
        in_ready_int  = (state_reg == IDLE) && !rst;
        out_valid_int = (state_reg == DONE);
    end

    // One-bit step for the latched op; c is the bit leaving (or wrapping) the word.
    always_comb begin
        step_y  = y_reg;
        step_c  = 1'b0;
        step_of = 1'b0;
        case (op_reg)
            3'b000: begin
                step_y = {y_reg[WIDTH-2:0], 1'b0};
                step_c = y_reg[WIDTH-1];
            end
            3'b001: begin
                step_y = {1'b0, y_reg[WIDTH-1:1]};
                step_c = y_reg[0];
            end
            3'b010: begin
                step_y  = {y_reg[WIDTH-2:0], 1'b0};
                step_c  = y_reg[WIDTH-1];
                // sign changes when the two top bits disagree before the step
                step_of = y_reg[WIDTH-1] ^ y_reg[WIDTH-2];
            end
            3'b011: begin
                step_y = {y_reg[WIDTH-1], y_reg[WIDTH-1:1]};
                step_c = y_reg[0];
            end
`ifdef SEQ_SHIFT_ROT_EN
            3'b100: begin
                step_y = {y_reg[WIDTH-2:0], y_reg[WIDTH-1]};
                step_c = y_reg[WIDTH-1];
            end
            3'b101: begin
                step_y = {y_reg[0], y_reg[WIDTH-1:1]};
                step_c = y_reg[0];
            end
`endif
            default: begin
                // pass-through: word unchanged, no carry, no overflow
                step_y  = y_reg;
                step_c  = 1'b0;
                step_of = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands at accept, then apply one step per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg   <= '0;
            c_reg   <= 1'b0;
            of_reg  <= 1'b0;
            cnt_reg <= '0;
            op_reg  <= 3'b000;
        end else if (accept) begin
            y_reg   <= bus.a;
            c_reg   <= 1'b0;
            of_reg  <= 1'b0;
            cnt_reg <= bus.shamt;
            op_reg  <= bus.op;
        end else if (step_en) begin
            y_reg   <= step_y;
            c_reg   <= step_c;
            of_reg  <= of_reg | step_of;
            cnt_reg <= cnt_reg - SHW'(1);
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.y         = y_reg;
    assign bus.c         = c_reg;
    assign bus.of        = of_reg;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed testbench for seq_shift_unit (WIDTH=16).
// Expected values are hand-computed; rotate expectations follow SEQ_SHIFT_ROT_EN.
module tb_seq_shift_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   lat;

    always #5 clk = ~clk;

    seq_shift_if #(.WIDTH(16)) bus ();

    seq_shift_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one operation for one cycle; it is accepted at the posedge
    // if the unit is idle. Inputs are scrambled afterwards to prove sampling.
    task automatic send(input logic [2:0] o, input logic [15:0] av, input logic [3:0] n);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = av;
        bus.shamt    = n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~av;
        bus.shamt    = ~n;
        bus.op       = 3'b011;
    endtask

    // Count edges after accept until out_valid, bounded.
    task automatic wait_result(output int l);
        l = 0;
        while (bus.out_valid !== 1'b1 && l < 40) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.a         = 16'h0000;
        bus.shamt     = 4'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_c", 32'(bus.c), 32'h0);
        chk("rst_of", 32'(bus.of), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

        // ASL 4000 N=1 -> 8000, of=1, c=0, latency 2
        send(3'b010, 16'h4000, 4'd1);
        wait_result(lat);
        $display("txn ASL a=4000 N=1 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("asl1_lat", 32'(lat), 32'd2);
        chk("asl1_y", 32'(bus.y), 32'h8000);
        chk("asl1_c", 32'(bus.c), 32'h0);
        chk("asl1_of", 32'(bus.of), 32'h1);
        chk("asl1_in_ready", 32'(bus.in_ready), 32'h0);
        consume();

        // ASL 2000 N=3 -> 0000, c=1, of sticky
        send(3'b010, 16'h2000, 4'd3);
        wait_result(lat);
        $display("txn ASL a=2000 N=3 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("asl3_lat", 32'(lat), 32'd4);
        chk("asl3_y", 32'(bus.y), 32'h0000);
        chk("asl3_c", 32'(bus.c), 32'h1);
        chk("asl3_of", 32'(bus.of), 32'h1);
        consume();

        // LSR 8001 N=4 -> 0800
        send(3'b001, 16'h8001, 4'd4);
        wait_result(lat);
        $display("txn LSR a=8001 N=4 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("lsr4_lat", 32'(lat), 32'd5);
        chk("lsr4_y", 32'(bus.y), 32'h0800);
        chk("lsr4_c", 32'(bus.c), 32'h0);
        chk("lsr4_of", 32'(bus.of), 32'h0);
        consume();

        // ASR 8000 N=15 -> FFFF, c=0
        send(3'b011, 16'h8000, 4'd15);
        wait_result(lat);
        $display("txn ASR a=8000 N=15 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("asr15_lat", 32'(lat), 32'd16);
        chk("asr15_y", 32'(bus.y), 32'hFFFF);
        chk("asr15_c", 32'(bus.c), 32'h0);
        consume();

        // LSL 1234 N=0 -> 1234 unchanged, latency 1
        send(3'b000, 16'h1234, 4'd0);
        wait_result(lat);
        $display("txn LSL a=1234 N=0 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("lsl0_lat", 32'(lat), 32'd1);
        chk("lsl0_y", 32'(bus.y), 32'h1234);
        chk("lsl0_c", 32'(bus.c), 32'h0);
        chk("lsl0_of", 32'(bus.of), 32'h0);
        chk("lsl0_in_ready", 32'(bus.in_ready), 32'h0);
        consume();

        // Backpressure: LSR F0F3 N=2 -> 3C3C c=1, held 5 cycles, second op ignored
        send(3'b001, 16'hF0F3, 4'd2);
        wait_result(lat);
        $display("txn LSR a=F0F3 N=2 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("bp_lat", 32'(lat), 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 3'b000;
        bus.a        = 16'hFFFF;
        bus.shamt    = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_y", 32'(bus.y), 32'h3C3C);
            chk("bp_c", 32'(bus.c), 32'h1);
            chk("bp_of", 32'(bus.of), 32'h0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        consume();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_extra_op", 32'(bus.out_valid), 32'h0);

        // Reset mid-SHIFT: LSL 0001 N=10, reset after 3 steps
        send(3'b000, 16'h0001, 4'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_y_before_rst", 32'(bus.y), 32'h0008);
        #1;
        rst = 1'b1;
        #1;
        $display("txn RST mid-shift y=%h c=%0d of=%0d out_valid=%0d", bus.y, bus.c, bus.of, bus.out_valid);
        chk("mid_rst_y", 32'(bus.y), 32'h0);
        chk("mid_rst_c", 32'(bus.c), 32'h0);
        chk("mid_rst_of", 32'(bus.of), 32'h0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Follow-up op after reset: ASR 8421 N=3 -> F084 c=0
        send(3'b011, 16'h8421, 4'd3);
        wait_result(lat);
        $display("txn ASR a=8421 N=3 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_y", 32'(bus.y), 32'hF084);
        chk("post_rst_c", 32'(bus.c), 32'h0);
        chk("post_rst_of", 32'(bus.of), 32'h0);
        consume();

        // ROL 8001 N=1: rotate when enabled, pass-through otherwise
        send(3'b100, 16'h8001, 4'd1);
        wait_result(lat);
        $display("txn ROL a=8001 N=1 y=%h c=%0d of=%0d lat=%0d", bus.y, bus.c, bus.of, lat);
        chk("rol_lat", 32'(lat), 32'd2);
`ifdef SEQ_SHIFT_ROT_EN
        chk("rol_y", 32'(bus.y), 32'h0003);
        chk("rol_c", 32'(bus.c), 32'h1);
`else
        chk("rol_y", 32'(bus.y), 32'h8001);
        chk("rol_c", 32'(bus.c), 32'h0);
`endif
        chk("rol_of", 32'(bus.of), 32'h0);
        consume();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
